// File: rtl/rx_bit_ctrl_pkg.sv
// rtl/rx_bit_ctrl_pkg.sv - shared state encoding, defaults and voter helper for the RX bit controller
package rx_bit_ctrl_pkg;

   localparam int DEF_OVERSAMPLE  = 16;
   localparam int DEF_DATA_BITS   = 8;
   localparam int DEF_SYNC_STAGES = 2;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } rx_state_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/rx_bit_ctrl_sync_vote.sv
// rtl/rx_bit_ctrl_sync_vote.sv - rx synchroniser and three-sample majority voter
import rx_bit_ctrl_pkg::*;

module rx_bit_ctrl_sync_vote #(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic i_baudclk,
   input  logic i_rst,
   input  logic i_rx,
   input  logic sample_a,
   input  logic sample_b,
   output logic rx_s,
   output logic vote
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   samp_a;
   logic                   samp_b;

   // Flops reset to the idle line level so reset never looks like a start bit.
   always_ff @(posedge i_baudclk) begin
      if (i_rst) begin
         sync_q <= '1;
         samp_a <= 1'b1;
         samp_b <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
         if (sample_a) samp_a <= sync_q[SYNC_STAGES-1];
         if (sample_b) samp_b <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rx_s = sync_q[SYNC_STAGES-1];

   // Third sample is the live synchronised line at the decision tick.
   assign vote = maj3(samp_a, samp_b, rx_s);

endmodule

// File: rtl/rx_bit_ctrl.sv
// rtl/rx_bit_ctrl.sv - UART receive bit controller driving SIPO shift/one/zero strobes
import rx_bit_ctrl_pkg::*;

module rx_bit_ctrl #(
   parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
   parameter int DATA_BITS   = DEF_DATA_BITS,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic i_baudclk,
   input  logic i_rst,
   input  logic i_rx,
   output logic o_shift,
   output logic o_onedetected,
   output logic o_zerodetected,
   output logic o_done,
   output logic o_frame_err,
   output logic o_busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam int M  = OVERSAMPLE / 2;

   localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] T_A    = TW'(M - 1);
   localparam logic [TW-1:0] T_B    = TW'(M);
   localparam logic [TW-1:0] T_DEC  = TW'(M + 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

   rx_state_t       state, state_nxt;
   logic [TW-1:0]   tick_cnt, tick_nxt;
   logic [BW-1:0]   bit_idx, bit_nxt;
   logic            shift_nxt, one_nxt, done_nxt, err_nxt;
   logic            rx_s, vote, dec;

   rx_bit_ctrl_sync_vote #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_vote (
      .i_baudclk (i_baudclk),
      .i_rst     (i_rst),
      .i_rx      (i_rx),
      .sample_a  (tick_cnt == T_A),
      .sample_b  (tick_cnt == T_B),
      .rx_s      (rx_s),
      .vote      (vote)
   );

   assign dec = (tick_cnt == T_DEC);

   always_ff @(posedge i_baudclk) begin
      if (i_rst) begin
         state          <= IDLE;
         tick_cnt       <= '0;
         bit_idx        <= '0;
         o_shift        <= 1'b0;
         o_onedetected  <= 1'b0;
         o_zerodetected <= 1'b0;
         o_done         <= 1'b0;
         o_frame_err    <= 1'b0;
      end else begin
         state          <= state_nxt;
         tick_cnt       <= tick_nxt;
         bit_idx        <= bit_nxt;
         o_shift        <= shift_nxt;
         o_onedetected  <= shift_nxt & one_nxt;
         o_zerodetected <= shift_nxt & ~one_nxt;
         o_done         <= done_nxt;
         o_frame_err    <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      tick_nxt  = (tick_cnt == T_LAST) ? '0 : tick_cnt + TW'(1);
      bit_nxt   = bit_idx;
      shift_nxt = 1'b0;
      one_nxt   = 1'b0;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         IDLE: begin
            tick_nxt = '0;
            if (!rx_s) state_nxt = START;
         end
         START: begin
            if (dec && vote) begin
               state_nxt = IDLE;
               tick_nxt  = '0;
            end else if (tick_cnt == T_LAST) begin
               state_nxt = DATA;
               bit_nxt   = '0;
            end
         end
         DATA: begin
            if (dec) begin
               shift_nxt = 1'b1;
               one_nxt   = vote;
            end
            if (tick_cnt == T_LAST) begin
               if (bit_idx == B_LAST) state_nxt = STOP;
               else                   bit_nxt   = bit_idx + BW'(1);
            end
         end
         STOP: begin
            // Leaving at mid stop bit re-arms IDLE before the next start edge.
            if (dec) begin
               tick_nxt = '0;
               if (vote) begin
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  err_nxt   = 1'b1;
                  state_nxt = WAIT_IDLE;
               end
            end
         end
         WAIT_IDLE: begin
            tick_nxt = '0;
            if (rx_s) state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            tick_nxt  = '0;
         end
      endcase
   end

   assign o_busy = (state == START) || (state == DATA) || (state == STOP);

endmodule
